// File: rtl/bist_pkg.sv
// Shared BIST definitions: ORA state encoding, CUT output width and the
// default MISR polynomial/seed used by both the pattern generator and the ORA.
package bist_pkg;

    localparam int unsigned CUT_OUT_W    = 9;
    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        COMPACT = 2'd2,
        DONE    = 2'd3
    } ora_state_t;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift left, fold in the polynomial when
// the MSB falls out, and XOR the parallel input word.
module bist_misr
    import bist_pkg::*;
#(
    parameter int unsigned          MISR_W = 16,
    parameter logic [MISR_W-1:0]    POLY   = MISR_W'(DEFAULT_POLY)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [MISR_W-1:0] seed,
    input  logic              en,
    input  logic [MISR_W-1:0] din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_step;

    // Next signature for one compaction cycle.
    always_comb begin
        sig_step = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? POLY : '0) ^ din;
    end

    // Signature register: reset clears, load seeds, en compacts, else hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= sig_step;
        end
    end

endmodule

// File: rtl/bist_response_analyzer.sv
// Output-response analyser: ignores a settle window, compacts the CUT outputs
// into a MISR for a fixed window, then compares against the golden signature.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int unsigned          MISR_W      = 16,
    parameter logic [MISR_W-1:0]    POLY        = MISR_W'(DEFAULT_POLY),
    parameter logic [MISR_W-1:0]    SEED        = MISR_W'(DEFAULT_SEED),
    parameter int unsigned          SKIP_CYCLES = 2,
    parameter int unsigned          N_CYCLES    = 1000,
    parameter int unsigned          CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              cut_fz_l,
    input  logic              cut_lclk,
    input  logic [4:0]        cut_read_a,
    input  logic [1:0]        cut_test_out,
    input  logic [MISR_W-1:0] golden_sig,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam longint unsigned MAX_CNT =
        (SKIP_CYCLES > N_CYCLES) ? longint'(SKIP_CYCLES) : longint'(N_CYCLES);
    localparam logic [CNT_W-1:0] SKIP_LAST =
        (SKIP_CYCLES > 0) ? CNT_W'(SKIP_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_CYCLES - 1);

    if (MISR_W < CUT_OUT_W || N_CYCLES < 1 || (64'd1 << CNT_W) <= MAX_CNT) begin : g_bad_params
        $error("bist_response_analyzer: illegal MISR_W/N_CYCLES/CNT_W");
    end

    ora_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pass_q, pass_d;
    logic              misr_load, misr_en;
    logic [MISR_W-1:0] cut_vec_ext;
    logic [MISR_W-1:0] sig_next;

    assign cut_vec_ext = MISR_W'({cut_fz_l, cut_lclk, cut_read_a, cut_test_out});

    bist_misr #(
        .MISR_W (MISR_W),
        .POLY   (POLY)
    ) u_misr (
        .clock  (clock),
        .reset  (reset),
        .load   (misr_load),
        .seed   (SEED),
        .en     (misr_en),
        .din    (cut_vec_ext),
        .sig    (signature)
    );

    // Mirror of the MISR step so the final update can be compared in the
    // same cycle it is registered.
    always_comb begin
        sig_next = {signature[MISR_W-2:0], 1'b0}
                 ^ (signature[MISR_W-1] ? POLY : '0)
                 ^ cut_vec_ext;
    end

    // State, counter and pass registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state, counter and MISR control; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        misr_load = 1'b1;
                        cnt_d     = '0;
                        pass_d    = 1'b0;
                        state_d   = (SKIP_CYCLES > 0) ? SKIP : COMPACT;
                    end
                end
                SKIP: begin
                    if (cnt_q == SKIP_LAST) begin
                        cnt_d   = '0;
                        state_d = COMPACT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                COMPACT: begin
                    misr_en = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == N_LAST) begin
                        state_d = DONE;
                        pass_d  = (sig_next == golden_sig);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q == SKIP) || (state_q == COMPACT);
    assign done = (state_q == DONE);
    assign pass = pass_q;

endmodule
